fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the IFU. Owns the architectural fetch PC register and drives the instruction-SRAM-like request bus: address phase, then data phase. It applies exception and jump redirects, including redirects that arrive while a request is in flight, and hands each fetched 1–2 instruction bundle to decode through a valid/ready register slice. Sits between the instruction bus and the ID stage and replaces free-running PC update in the front end.

## Interface
- RESET_PC, 32'hBFC0_0000, PC loaded on reset
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- exception_pc_ena  in  1  exception redirect request, highest priority
- exception_pc  in  32  exception redirect target
- id_take_jmp  in  1  branch/jump redirect from ID
- id_jmp_target  in  32  jump target
- flush_req  out  1  redirect taken this cycle; asks ID to flush
- inst_req  out  1  address-phase request
- inst_addr  out  32  fetch address (= pc)
- inst_addr_ok  in  1  address accepted this cycle
- inst_data_ok  in  1  response valid this cycle
- inst_rdata_1  in  32  instruction at addr
- inst_rdata_2  in  32  instruction at addr+4
- inst_rdata_1_ok  in  1  slot 1 valid; qualified by data_ok
- inst_rdata_2_ok  in  1  slot 2 valid; qualified by data_ok
- out_valid  out  1  bundle valid to decode
- out_ready  in  1  decode accepts bundle
- out_pc  out  32  PC of slot 1
- out_inst_1  out  32  slot 1 instruction
- out_inst_2  out  32  slot 2 instruction
- out_inst_2_valid  out  1  slot 2 holds a real instruction

## Operation
- redirect = exception_pc_ena | id_take_jmp. Target is exception_pc if exception_pc_ena, else id_jmp_target.
- flush_req = id_take_jmp | exception_pc_ena. Combinational; it is the only combinational output.
- One outstanding request maximum.
- States REQ, WAIT, DROP, HOLD.
- REQ:
  - inst_req=1, inst_addr=pc.
  - addr_ok & !redirect → WAIT.
  - addr_ok & redirect → pc<=target, DROP (the stale request is in flight).
  - !addr_ok & redirect → pc<=target, stay REQ. The address may change while unaccepted.
- WAIT:
  - inst_req=0.
  - data_ok & !redirect → capture bundle into output slice.
    - out_pc=pc.
    - out_inst_2_valid = rdata_1_ok & rdata_2_ok.
    - pc <= pc + 4*n, where n = rdata_1_ok + (rdata_1_ok & rdata_2_ok).
    - If n=0: no capture, pc unchanged, → REQ (refetch).
    - Otherwise → HOLD.
  - data_ok & redirect → discard response, pc<=target, → REQ.
  - !data_ok & redirect → pc<=target, → DROP.
- DROP:
  - inst_req=0.
  - data_ok → discard, → REQ.
  - A further redirect only updates pc; the state stays DROP.
- HOLD:
  - out_valid=1, contents stable until handshake.
  - out_ready & !redirect → out_valid<=0, → REQ.
  - redirect (with or without out_ready) → out_valid<=0, pc<=target, → REQ. The bundle is killed even if accepted the same cycle.
- rdata_2_ok without rdata_1_ok counts as n=0.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+8 wraps to 32'h0000_0004.

## Timing
- Reset values: state=REQ, pc=RESET_PC, out_valid=0, out_pc=0, out_inst_1=0, out_inst_2=0, out_inst_2_valid=0.
- inst_req=1 from the first cycle after reset deassertion.
- Reset mid-operation: all state is lost. The bus is reset by the same resetn, so no stale response survives.
- Best-case latency, addr_ok to out_valid: addr_ok at edge N, data_ok at N+1, out_valid from N+2.
- Best-case throughput: one bundle every 3 cycles.
- Redirect latency: inst_addr = target on the first REQ cycle after the redirect edge. When a stale request is pending, that is after its data_ok has been observed.
- Inputs are sampled only at rising clk. The redirect has effect in the same cycle it is high; there is no latching of redirect inputs.

## Structure
- Package gemini_ifu_pkg:
  - fetch_state_t enum (REQ, WAIT, DROP, HOLD)
  - RESET_PC default constant
  - INST_BYTES=4
- Sub-module fetch_out_buf: valid/ready holding register for pc and the two instruction slots, with kill input.
- fetch_ctrl holds the FSM, the pc register and target selection.

## Test plan
- Reset release, addr_ok and data_ok immediate, both slots ok, out_ready=1 → out_pc=BFC0_0000 with 2 instructions; next inst_addr=BFC0_0008.
- Only rdata_1_ok → out_inst_2_valid=0; next inst_addr=BFC0_0004.
- Jump to 8000_1000 in WAIT without data_ok; data_ok two cycles later → response discarded, out_valid stays 0, then inst_addr=8000_1000.
- exception_pc_ena and id_take_jmp in the same cycle → pc=exception_pc, flush_req=1.
- HOLD with out_ready=0 for 5 cycles → outputs stable, no inst_req. A redirect during HOLD → out_valid drops next cycle, fetch resumes at target.
- pc=FFFF_FFFC, both ok → next inst_addr=0000_0004. Assert resetn low while in WAIT → state REQ, pc=BFC0_0000, out_valid=0.

Source files
------------

// File: rtl/gemini_ifu_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package gemini_ifu_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
    localparam int          INST_BYTES = 4;

    // Slot 2 only counts when slot 1 is also valid.
    function automatic logic [31:0] fetch_incr(input logic ok_1, input logic ok_2);
        logic [31:0] incr;
        incr = '0;
        if (ok_1) begin
            incr = ok_2 ? 32'(2 * INST_BYTES) : 32'(INST_BYTES);
        end
        return incr;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction bus plus the decode-side bundle slice of the fetch sequencer.
interface fetch_ctrl_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata_1;
    logic [31:0] inst_rdata_2;
    logic        inst_rdata_1_ok;
    logic        inst_rdata_2_ok;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst_1;
    logic [31:0] out_inst_2;
    logic        out_inst_2_valid;

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata_1, inst_rdata_2,
        input  inst_rdata_1_ok, inst_rdata_2_ok,
        output out_valid, out_pc, out_inst_1, out_inst_2, out_inst_2_valid,
        input  out_ready
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata_1, inst_rdata_2,
        output inst_rdata_1_ok, inst_rdata_2_ok,
        input  out_valid, out_pc, out_inst_1, out_inst_2, out_inst_2_valid,
        output out_ready
    );
endinterface

// File: rtl/fetch_out_buf.sv
// Valid/ready holding register for one fetched bundle; kill drops it unconditionally.
module fetch_out_buf (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        kill,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst_1_in,
    input  logic [31:0] inst_2_in,
    input  logic        inst_2_valid_in,
    input  logic        ready,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] inst_1,
    output logic [31:0] inst_2,
    output logic        inst_2_valid
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid        <= 1'b0;
            pc           <= '0;
            inst_1       <= '0;
            inst_2       <= '0;
            inst_2_valid <= 1'b0;
        end else if (load) begin
            valid        <= 1'b1;
            pc           <= pc_in;
            inst_1       <= inst_1_in;
            inst_2       <= inst_2_in;
            inst_2_valid <= inst_2_valid_in;
        end else if (kill || (valid && ready)) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, drives the instruction bus and applies redirects.
//   state | meaning
//   REQ   | address phase, inst_req high with inst_addr = pc
//   WAIT  | request accepted, waiting for its response
//   DROP  | stale request in flight, its response is discarded
//   HOLD  | bundle held in output slice until decode accepts it
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = gemini_ifu_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              exception_pc_ena,
    input  logic [31:0]       exception_pc,
    input  logic              id_take_jmp,
    input  logic [31:0]       id_jmp_target,
    output logic              flush_req,
    fetch_ctrl_if.master      bus
);
    import gemini_ifu_pkg::*;

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  target;
    logic [31:0]  incr;
    logic         redirect;
    logic         inst_req;
    logic         load;
    logic         kill;

    assign redirect      = exception_pc_ena | id_take_jmp;
    assign target        = exception_pc_ena ? exception_pc : id_jmp_target;
    assign flush_req     = redirect;
    assign incr          = fetch_incr(bus.inst_rdata_1_ok, bus.inst_rdata_2_ok);
    assign bus.inst_req  = inst_req;
    assign bus.inst_addr = pc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= REQ;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        inst_req   = 1'b0;
        load       = 1'b0;
        kill       = 1'b0;
        unique case (state)
            REQ: begin
                inst_req = 1'b1;
                if (bus.inst_addr_ok) state_next = redirect ? DROP : WAIT;
            end
            WAIT: begin
                if (bus.inst_data_ok) begin
                    if (redirect || incr == '0) begin
                        state_next = REQ;
                    end else begin
                        load       = 1'b1;
                        pc_next    = pc + incr;
                        state_next = HOLD;
                    end
                end else if (redirect) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (bus.inst_data_ok) state_next = REQ;
            end
            HOLD: begin
                // A redirect kills the bundle even when decode accepts it this cycle.
                if (redirect) begin
                    kill       = 1'b1;
                    state_next = REQ;
                end else if (bus.out_ready) begin
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase
        if (redirect) pc_next = target;
    end

    fetch_out_buf u_out_buf (
        .clk             (clk),
        .resetn          (resetn),
        .load            (load),
        .kill            (kill),
        .pc_in           (pc),
        .inst_1_in       (bus.inst_rdata_1),
        .inst_2_in       (bus.inst_rdata_2),
        .inst_2_valid_in (bus.inst_rdata_1_ok & bus.inst_rdata_2_ok),
        .ready           (bus.out_ready),
        .valid           (bus.out_valid),
        .pc              (bus.out_pc),
        .inst_1          (bus.out_inst_1),
        .inst_2          (bus.out_inst_2),
        .inst_2_valid    (bus.out_inst_2_valid)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a bundle scoreboard.
module tb_fetch_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] i1;
        logic [31:0] i2;
        logic        v2;
    } bundle_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        exc;
    logic [31:0] epc;
    logic        jmp;
    logic [31:0] jtgt;
    logic        flush_req;
    int          total = 0;
    int          bad = 0;
    bundle_t     sb[$];

    fetch_ctrl_if bus ();

    fetch_ctrl dut (
        .clk              (clk),
        .resetn           (resetn),
        .exception_pc_ena (exc),
        .exception_pc     (epc),
        .id_take_jmp      (jmp),
        .id_jmp_target    (jtgt),
        .flush_req        (flush_req),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare any handshake due at the coming edge, then advance one cycle.
    task automatic tick();
        bundle_t e;
        #1;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 32'(bus.out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                if (!(exc | jmp)) begin
                    chk("sb_pc", bus.out_pc, e.pc);
                    chk("sb_inst_1", bus.out_inst_1, e.i1);
                    chk("sb_inst_2", bus.out_inst_2, e.i2);
                    chk("sb_inst_2_valid", 32'(bus.out_inst_2_valid), 32'(e.v2));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic ok1, input logic ok2, input logic [31:0] i1,
                         input logic [31:0] i2, input logic [31:0] exp_pc);
        bundle_t e;
        chk("req_high", 32'(bus.inst_req), 32'd1);
        chk("req_addr", bus.inst_addr, exp_pc);
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        chk("wait_no_req", 32'(bus.inst_req), 32'd0);
        chk("wait_no_valid", 32'(bus.out_valid), 32'd0);
        bus.inst_data_ok    = 1'b1;
        bus.inst_rdata_1    = i1;
        bus.inst_rdata_2    = i2;
        bus.inst_rdata_1_ok = ok1;
        bus.inst_rdata_2_ok = ok2;
        if (ok1) begin
            e.pc = exp_pc; e.i1 = i1; e.i2 = i2; e.v2 = ok1 & ok2;
            sb.push_back(e);
        end
        tick();
        bus.inst_data_ok    = 1'b0;
        bus.inst_rdata_1_ok = 1'b0;
        bus.inst_rdata_2_ok = 1'b0;
        chk("cap_valid", 32'(bus.out_valid), 32'(ok1));
    endtask

    initial begin
        resetn = 1'b0;
        exc = 1'b0; epc = '0; jmp = 1'b0; jtgt = '0;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0;
        bus.inst_rdata_1 = '0; bus.inst_rdata_2 = '0;
        bus.inst_rdata_1_ok = 1'b0; bus.inst_rdata_2_ok = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk("rst_out_inst_1", bus.out_inst_1, 32'd0);
        chk("rst_out_inst_2", bus.out_inst_2, 32'd0);
        chk("rst_out_inst_2_valid", 32'(bus.out_inst_2_valid), 32'd0);
        chk("rst_flush", 32'(flush_req), 32'd0);
        resetn = 1'b1;
        tick();

        // Two-slot bundle, then single slot, then n=0 refetch.
        fetch(1'b1, 1'b1, 32'h1111_0001, 32'h2222_0002, 32'hBFC0_0000);
        chk("hold_inst_2_valid", 32'(bus.out_inst_2_valid), 32'd1);
        tick();
        chk("next_addr_2", bus.inst_addr, 32'hBFC0_0008);
        fetch(1'b1, 1'b0, 32'h3333_0003, 32'h4444_0004, 32'hBFC0_0008);
        chk("hold_inst_2_invalid", 32'(bus.out_inst_2_valid), 32'd0);
        tick();
        chk("next_addr_1", bus.inst_addr, 32'hBFC0_000C);
        fetch(1'b0, 1'b1, 32'h5555_0005, 32'h6666_0006, 32'hBFC0_000C);
        chk("n0_addr", bus.inst_addr, 32'hBFC0_000C);
        chk("n0_req", 32'(bus.inst_req), 32'd1);

        // Jump while waiting; stale response two cycles later is dropped.
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        jmp = 1'b1; jtgt = 32'h8000_1000;
        #1;
        chk("jmp_flush", 32'(flush_req), 32'd1);
        tick();
        jmp = 1'b0;
        chk("drop_no_req", 32'(bus.inst_req), 32'd0);
        tick();
        chk("drop_no_req2", 32'(bus.inst_req), 32'd0);
        bus.inst_data_ok = 1'b1; bus.inst_rdata_1_ok = 1'b1; bus.inst_rdata_2_ok = 1'b1;
        tick();
        bus.inst_data_ok = 1'b0; bus.inst_rdata_1_ok = 1'b0; bus.inst_rdata_2_ok = 1'b0;
        chk("drop_no_valid", 32'(bus.out_valid), 32'd0);
        chk("drop_req", 32'(bus.inst_req), 32'd1);
        chk("jmp_addr", bus.inst_addr, 32'h8000_1000);

        // Exception beats jump.
        exc = 1'b1; epc = 32'h0000_0380; jmp = 1'b1; jtgt = 32'h1234_5678;
        #1;
        chk("both_flush", 32'(flush_req), 32'd1);
        tick();
        exc = 1'b0; jmp = 1'b0;
        chk("exc_addr", bus.inst_addr, 32'h0000_0380);
        chk("exc_req", 32'(bus.inst_req), 32'd1);

        // Stall in HOLD, then redirect kills the bundle.
        bus.out_ready = 1'b0;
        fetch(1'b1, 1'b1, 32'hAAAA_000A, 32'hBBBB_000B, 32'h0000_0380);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_pc", bus.out_pc, 32'h0000_0380);
            chk("stall_inst_1", bus.out_inst_1, 32'hAAAA_000A);
            chk("stall_no_req", 32'(bus.inst_req), 32'd0);
        end
        jmp = 1'b1; jtgt = 32'h0000_2000;
        tick();
        jmp = 1'b0;
        void'(sb.pop_front());
        chk("kill_valid", 32'(bus.out_valid), 32'd0);
        chk("kill_addr", bus.inst_addr, 32'h0000_2000);
        chk("kill_req", 32'(bus.inst_req), 32'd1);

        // Redirect coinciding with acceptance still kills the bundle.
        bus.out_ready = 1'b1;
        fetch(1'b1, 1'b0, 32'hCCCC_000C, 32'hDDDD_000D, 32'h0000_2000);
        jmp = 1'b1; jtgt = 32'h0000_3000;
        tick();
        jmp = 1'b0;
        chk("kill_acc_valid", 32'(bus.out_valid), 32'd0);
        chk("kill_acc_addr", bus.inst_addr, 32'h0000_3000);

        // PC wrap.
        jmp = 1'b1; jtgt = 32'hFFFF_FFFC;
        tick();
        jmp = 1'b0;
        fetch(1'b1, 1'b1, 32'hEEEE_000E, 32'hFFFF_000F, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr", bus.inst_addr, 32'h0000_0004);

        // Reset while waiting on a response.
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        chk("pre_rst_no_req", 32'(bus.inst_req), 32'd0);
        resetn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_addr", bus.inst_addr, 32'hBFC0_0000);
        chk("mid_rst_req", 32'(bus.inst_req), 32'd1);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        fetch(1'b1, 1'b1, 32'h0101_0101, 32'h0202_0202, 32'hBFC0_0000);
        tick();
        chk("post_rst_addr", bus.inst_addr, 32'hBFC0_0008);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
